// File: rtl/dsp_config_sequencer_if.sv
// Configuration and FIR-control bundle for the DSP reload sequencer.
// The master side supplies the reload requests and coefficient beats.
// The slave side (the sequencer) drives the FIR port and the datapath gates.
interface dsp_config_sequencer_if #(
  parameter int COEF_W = 12,
  parameter int ADDR_W = 4
);
  logic              cfg_start;
  logic              cfg_abort;
  logic [COEF_W-1:0] cfg_coef;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              fir_write_en;
  logic [ADDR_W-1:0] fir_addr;
  logic [COEF_W-1:0] fir_coefficient;
  logic              dp_enable;
  logic              out_valid_gate;
  logic              coef_valid;
  logic              busy;
  logic              done;

  modport master (
    output cfg_start, cfg_abort, cfg_coef, cfg_valid,
    input  cfg_ready, fir_write_en, fir_addr, fir_coefficient,
    input  dp_enable, out_valid_gate, coef_valid, busy, done
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_coef, cfg_valid,
    output cfg_ready, fir_write_en, fir_addr, fir_coefficient,
    output dp_enable, out_valid_gate, coef_valid, busy, done
  );
endinterface

// File: rtl/dsp_config_sequencer.sv
// Reload controller for the upsampler -> FIR -> storage chain.
// Halts the datapath, streams a coefficient set into the FIR, flushes the
// delay line with output gated off, then re-enables validated output.
module dsp_config_sequencer #(
  parameter int NUM_TAPS     = 16,
  parameter int COEF_W       = 12,
  parameter int ADDR_W       = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  dsp_config_sequencer_if.slave   bus
);

  // One shared counter times both DRAIN and FLUSH; it only has to reach max-1.
  localparam int CNT_MAX = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_LOAD,
    S_FLUSH,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic              wr_q, wr_d;
  logic              coef_valid_q, coef_valid_d;
  logic              done_q, done_d;
  logic              accept;

  // Abort withdraws ready in the same cycle so an aborted beat is never taken.
  assign bus.cfg_ready = (state_q == S_LOAD) && !bus.cfg_abort;
  assign accept        = bus.cfg_ready && bus.cfg_valid;

  assign bus.fir_write_en    = wr_q;
  assign bus.fir_addr        = addr_q;
  assign bus.fir_coefficient = coef_q;
  assign bus.dp_enable       = (state_q == S_FLUSH) || (state_q == S_RUN);
  assign bus.out_valid_gate  = (state_q == S_RUN);
  assign bus.busy            = (state_q == S_DRAIN) || (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign bus.coef_valid      = coef_valid_q;
  assign bus.done            = done_q;

  // State and datapath registers; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      addr_q       <= '0;
      coef_q       <= '0;
      wr_q         <= 1'b0;
      coef_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      addr_q       <= addr_d;
      coef_q       <= coef_d;
      wr_q         <= wr_d;
      coef_valid_q <= coef_valid_d;
      done_q       <= done_d;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    addr_d       = addr_q;
    coef_d       = coef_q;
    wr_d         = 1'b0;
    coef_valid_d = coef_valid_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.cfg_start) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (bus.cfg_abort) begin
          // Coefficients were never touched, so fall back to whatever was running.
          state_d = coef_valid_q ? S_RUN : S_IDLE;
        end else if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d      = S_LOAD;
          tap_d        = '0;
          coef_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (bus.cfg_abort) begin
          state_d      = S_IDLE;
          coef_valid_d = 1'b0;
        end else if (accept) begin
          wr_d   = 1'b1;
          addr_d = tap_q;
          coef_d = bus.cfg_coef;
          tap_d  = tap_q + ADDR_W'(1);
          if (tap_q == ADDR_W'(NUM_TAPS - 1)) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end
        end
      end
      S_FLUSH: begin
        if (bus.cfg_start) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d      = S_RUN;
          done_d       = 1'b1;
          coef_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
